// File: rtl/mem_stall_controller_if.sv
// Word-serial main memory transfer bus between the miss sequencer and memory.
interface mem_stall_controller_if;
  logic        memReq;
  logic        memWe;
  logic [31:0] memAddr;
  logic        memReady;

  modport master (output memReq, output memWe, output memAddr, input memReady);
  modport slave  (input memReq, input memWe, input memAddr, output memReady);
endinterface

// File: rtl/mem_stall_controller.sv
// MEM-stage data-cache miss sequencer: stalls the pipeline, writes back a dirty
// victim line and refills the indexed line word by word from main memory.
module mem_stall_controller #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned WORDS   = 4,
  localparam int unsigned WORD_W   = $clog2(WORDS),
  localparam int unsigned OFFSET_W = WORD_W + 2,
  localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 memRead,
  input  logic                 memWrite,
  input  logic [31:0]          address,
  input  logic                 tagMatch,
  input  logic                 lineValid,
  input  logic                 lineDirty,
  input  logic [TAG_W-1:0]     lineTag,
  mem_stall_controller_if.master mem,
  output logic                 hit,
  output logic [WORD_W-1:0]    wordIndex,
  output logic                 fillWrite,
  output logic                 tagWrite,
  output logic                 dirtySet,
  output logic [15:0]          missCount
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] WB     = 2'd1;
  localparam logic [1:0] FILL   = 2'd2;
  localparam logic [1:0] UPDATE = 2'd3;

  logic [1:0]        state;
  logic [1:0]        stateNext;
  logic [WORD_W-1:0] wordNext;
  logic [15:0]       missNext;
  logic              access;
  logic              lookupHit;
  logic              lastWord;
  logic              unusedOffset;

  assign access       = memRead | memWrite;
  assign lookupHit    = tagMatch & lineValid;
  assign lastWord     = (wordIndex == WORD_W'(WORDS - 1));
  // Byte/word offset of the access is irrelevant: whole lines are transferred.
  assign unusedOffset = ^address[OFFSET_W-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      wordIndex <= '0;
      missCount <= '0;
    end else begin
      state     <= stateNext;
      wordIndex <= wordNext;
      missCount <= missNext;
    end
  end

  // Next state, word counter and all strobes decoded from the current state.
  always_comb begin
    stateNext   = state;
    wordNext    = wordIndex;
    missNext    = missCount;
    hit         = 1'b0;
    dirtySet    = 1'b0;
    fillWrite   = 1'b0;
    tagWrite    = 1'b0;
    mem.memReq  = 1'b0;
    mem.memWe   = 1'b0;
    mem.memAddr = '0;
    case (state)
      IDLE: begin
        hit      = !access | lookupHit;
        dirtySet = memWrite & lookupHit;
        wordNext = '0;
        if (access && !lookupHit) begin
          stateNext = (lineValid && lineDirty) ? WB : FILL;
          if (missCount != 16'hFFFF) missNext = missCount + 16'd1;
        end
      end
      WB: begin
        mem.memReq  = 1'b1;
        mem.memWe   = 1'b1;
        mem.memAddr = {lineTag, address[INDEX_W+OFFSET_W-1:OFFSET_W], wordIndex, 2'b00};
        if (mem.memReady) begin
          wordNext = wordIndex + WORD_W'(1);
          if (lastWord) stateNext = FILL;
        end
      end
      FILL: begin
        mem.memReq  = 1'b1;
        mem.memAddr = {address[31:OFFSET_W], wordIndex, 2'b00};
        fillWrite   = mem.memReady;
        if (mem.memReady) begin
          wordNext = wordIndex + WORD_W'(1);
          if (lastWord) stateNext = UPDATE;
        end
      end
      UPDATE: begin
        tagWrite  = 1'b1;
        stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: doc/mem_stall_controller.md
# mem_stall_controller

Data-cache miss sequencer for the MEM stage. It watches the access flags and address latched in the EX/MEM pipeline register. It produces the `hit` advance signal that gates that register and the rest of the pipeline. On a miss it writes back a dirty victim line and refills the line from main memory over a word-serial req/ready handshake, driving the cache array write strobes while it does so.

## Interface
- `INDEX_W`, 6: cache index bits (64 lines, direct-mapped).
- `WORDS`, 4: 32-bit words per line; power of two, ≥2. `WORD_W = log2(WORDS)`, `OFFSET_W = WORD_W + 2`, `TAG_W = 32 - INDEX_W - OFFSET_W`.
- `clock`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `memRead`  in  1  load in MEM stage (from EX/MEM `memReadOut`).
- `memWrite`  in  1  store in MEM stage (from EX/MEM `memWriteOut`).
- `address`  in  32  byte address (from EX/MEM `ALUResultOut`).
- `tagMatch`  in  1  stored tag of indexed line equals `address` tag.
- `lineValid`  in  1  valid bit of indexed line.
- `lineDirty`  in  1  dirty bit of indexed line.
- `lineTag`  in  TAG_W  stored tag of indexed line (victim tag).
- `memReady`  in  1  main memory accepts/completes current word this cycle.
- `hit`  out  1  pipeline advance; 1 = MEM access satisfied or no access.
- `memReq`  out  1  word transfer request to main memory.
- `memWe`  out  1  1 = write-back word, 0 = refill read.
- `memAddr`  out  32  word-aligned main memory address.
- `wordIndex`  out  WORD_W  cache word currently transferred.
- `fillWrite`  out  1  write `memRdata` into cache word `wordIndex` this cycle.
- `tagWrite`  out  1  load tag from `address`, set valid, clear dirty.
- `dirtySet`  out  1  set dirty bit of indexed line (store hit).
- `missCount`  out  16  saturating count of misses since reset.

## Operation
- `access = memRead | memWrite`. `lookupHit = tagMatch & lineValid`. Both reads and writes use write-allocate, write-back.
- The FSM has four states: IDLE, WB, FILL, UPDATE.
- IDLE:
  - `hit = !access | lookupHit` (combinational).
  - `dirtySet = memWrite & lookupHit`.
  - On `access & !lookupHit`: go to WB if `lineValid & lineDirty`, else go to FILL.
  - `wordIndex` clears to 0 and `missCount` increments (holds at 0xFFFF).
- WB:
  - `memReq=1`, `memWe=1`, `memAddr = {lineTag, address[INDEX_W+OFFSET_W-1:OFFSET_W], wordIndex, 2'b00}`.
  - A rising edge with `memReady=1` completes the word and `wordIndex` increments.
  - Completing word WORDS-1 moves to FILL with `wordIndex` wrapping to 0.
- FILL:
  - `memReq=1`, `memWe=0`, `memAddr = {address[31:OFFSET_W], wordIndex, 2'b00}`, `fillWrite = memReady`.
  - Completing word WORDS-1 moves to UPDATE.
- UPDATE: `tagWrite=1` for one cycle, then go to IDLE. The next IDLE cycle sees `lookupHit=1`, so `hit=1`; a store asserts `dirtySet` then.
- Outside IDLE: `hit=0` and `dirtySet=0`. `memReq=0`, `fillWrite=0` and `tagWrite=0` except as stated above.
- `address`, `memRead` and `memWrite` are held stable by the stalled EX/MEM register throughout a miss, so the controller does not latch them.
- `memRead` and `memWrite` both high is treated as a single access.

## Timing
- Reset values: state IDLE, `wordIndex=0`, `missCount=0`. Hence `memReq=0`, `fillWrite=0`, `tagWrite=0`, and `hit` follows the IDLE equation.
- `hit` must settle before the falling edge, where EX/MEM samples it.
- Handshake:
  - `memReq`, `memWe` and `memAddr` stay stable until a rising edge samples `memReady=1`.
  - `memReady` may already be high in the first request cycle.
  - At most one word completes per cycle.
  - `memReady` is ignored while `memReq=0`.
- Clean miss with `memReady` always 1:
  - detect in cycle 0, FILL in cycles 1..WORDS, UPDATE in cycle WORDS+1;
  - `hit=1` in cycle WORDS+2, i.e. 6 stall cycles for WORDS=4.
- A dirty miss adds WORDS cycles. Each memory wait cycle adds one cycle.
- Reset during WB, FILL or UPDATE: the next cycle is IDLE with `memReq=0`, no `tagWrite`, and the line is left unchanged.
- A miss immediately after UPDATE for a different address starts a new miss from IDLE. There is no back-to-back shortcut.

## Test plan
- Load hit (`tagMatch=1`, `lineValid=1`) -> `hit=1` in the same cycle, `memReq` stays 0, `missCount` stays 0.
- Store hit -> `hit=1`, `dirtySet=1` for one cycle, no memory traffic.
- Clean load miss to 0x0000_1234, `memReady=1` -> FILL addresses 0x1230, 0x1234, 0x1238, 0x123C with `fillWrite` on each; `tagWrite` on cycle 5; `hit=1` on cycle 6; `missCount=1`.
- Dirty store miss, `lineTag` = victim tag, `memReady` toggling 0/1 -> 4 write-back words at the victim address with `memWe=1`, then 4 refill words. Request signals hold stable during `memReady=0` cycles. `dirtySet=1` when back in IDLE.
- Assert `reset` mid-FILL at word 2 -> next cycle IDLE, `memReq=0`, `wordIndex=0`, `missCount=0`, no `tagWrite`.
- Force `missCount` to 0xFFFF via 65535 misses (or a backdoor preload), then one more miss -> `missCount` holds 0xFFFF.
